// File: rtl/onehot_pkg.sv
// onehot_pkg: shared types and helpers for one-hot stream blocks
package onehot_pkg;
  typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_TWO} skid_state_e;
  function automatic bit is_onehot(input logic [63:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction
endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: two-entry valid/ready register slice with registered ready and valid
module skid_buffer
  import onehot_pkg::*;
#(
  parameter int DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataWidth-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataWidth-1:0] out_data
);
  skid_state_e state_q, state_d;
  logic [DataWidth-1:0] out_q, out_d, skid_q, skid_d;
  logic ready_q, in_xfer, out_xfer;
  assign in_ready  = ready_q;
  assign out_valid = state_q != SKID_EMPTY;
  assign out_data  = out_q;
  assign in_xfer   = in_valid && ready_q;
  assign out_xfer  = out_valid && out_ready;
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: if (in_xfer) begin
        state_d = SKID_ONE;
        out_d   = in_data;
      end
      SKID_ONE: if (in_xfer && out_xfer) out_d = in_data;
        else if (in_xfer) begin
          state_d = SKID_TWO;
          skid_d  = in_data;
        end else if (out_xfer) state_d = SKID_EMPTY;
      SKID_TWO: if (out_xfer) begin
        state_d = SKID_ONE;
        out_d   = skid_q;
      end
      default: state_d = SKID_EMPTY;
    endcase
  end
  // ready is its own flop so it stays low in the reset cycle and rises on the first edge after release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SKID_EMPTY;
      ready_q <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= state_d != SKID_TWO;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: rtl/onehot_demux_stream.sv
// onehot_demux_stream: one-hot routed 1-to-Count valid/ready demux, dropping and counting illegal selects
module onehot_demux_stream
  import onehot_pkg::*;
#(
  parameter int Count        = 4,
  parameter int Width        = 32,
  parameter int DropCntWidth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [Count-1:0]        select_i,
  input  logic [Width-1:0]        word_i,
  output logic [Count-1:0]        valid_o,
  input  logic [Count-1:0]        ready_i,
  output logic [Width-1:0]        word_o,
  output logic [DropCntWidth-1:0] drop_count_o,
  output logic                    drop_o
);
  logic legal, buf_valid, drop_accept;
  logic [Count+Width-1:0] buf_data;
  assign legal       = is_onehot(64'(select_i));
  assign drop_accept = valid_i && ready_o && !legal;
  skid_buffer #(.DataWidth(Count + Width)) u_skid (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (valid_i && legal),
    .in_ready  (ready_o),
    .in_data   ({select_i, word_i}),
    .out_valid (buf_valid),
    .out_ready (|(valid_o & ready_i)),
    .out_data  (buf_data)
  );
  assign valid_o = buf_valid ? buf_data[Count+Width-1:Width] : '0;
  assign word_o  = buf_data[Width-1:0];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_o       <= 1'b0;
      drop_count_o <= '0;
    end else begin
      drop_o <= drop_accept;
      if (drop_accept && drop_count_o != '1) drop_count_o <= drop_count_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_onehot_demux_stream.sv
// tb_onehot_demux_stream: scoreboard bench for onehot_demux_stream (Count=4, Width=8, DropCntWidth=2)
module tb_onehot_demux_stream;
  logic       clk = 0, rst_ni = 0, valid_i = 0, ready_o, drop_o;
  logic [3:0] select_i = 0, valid_o, ready_i = 0;
  logic [7:0] word_i = 0, word_o;
  logic [1:0] drop_count_o;
  int vectors = 0, miscompares = 0, out_cnt = 0;
  logic [11:0] sb[$];
  logic [1:0] exp_cnt = 0;
  logic exp_drop = 0;

  onehot_demux_stream #(.Count(4), .Width(8), .DropCntWidth(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .select_i(select_i), .word_i(word_i), .valid_o(valid_o), .ready_i(ready_i),
    .word_o(word_o), .drop_count_o(drop_count_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // inputs change only at posedge+1, so negedge values are what the next edge will see
  always @(negedge clk) if (rst_ni) begin
    logic [11:0] e;
    check("drop_o", 32'(drop_o), 32'(exp_drop));
    check("drop_cnt", 32'(drop_count_o), 32'(exp_cnt));
    if (|(valid_o & ready_i)) begin
      out_cnt++;
      if (sb.size() == 0) check("spurious", 32'(valid_o), 0);
      else begin
        e = sb.pop_front();
        check("out_sel", 32'(valid_o), 32'(e[11:8]));
        check("out_word", 32'(word_o), 32'(e[7:0]));
      end
    end
    exp_drop = 0;
    if (valid_i && ready_o) begin
      if ($onehot(select_i)) sb.push_back({select_i, word_i});
      else begin
        exp_drop = 1;
        if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      end
    end
  end

  task automatic send(input logic [3:0] s, input logic [7:0] w);
    valid_i = 1; select_i = s; word_i = w;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ready_o) begin
        @(posedge clk); #1;
        valid_i = 0;
        return;
      end
    end
    check("send_timeout", 0, 1);
    valid_i = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    repeat (2) tick();
    check("rst_ready", 32'(ready_o), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_word", 32'(word_o), 0);
    check("rst_cnt", 32'(drop_count_o), 0);
    check("rst_drop", 32'(drop_o), 0);
    @(negedge clk); rst_ni = 1; #1;
    check("ready_pre_edge", 32'(ready_o), 0);
    tick();
    check("ready_first_edge", 32'(ready_o), 1);

    ready_i = 4'hf;
    send(4'b0100, 8'hA5);
    check("t1_valid", 32'(valid_o), 32'h4);
    check("t1_word", 32'(word_o), 32'hA5);
    tick();
    check("t1_one_cycle", 32'(valid_o), 0);

    for (int i = 0; i < 8; i++) begin
      logic [3:0] s;
      s = 4'b0001 << (i % 4);
      send(s, 8'(i + 1));
      check("t2_ready", 32'(ready_o), 1);
      check("t2_valid", 32'(valid_o), 32'(s));
      check("t2_word", 32'(word_o), i + 1);
    end
    tick();

    ready_i = 4'h0;
    send(4'b0001, 8'h10);
    send(4'b0010, 8'h11);
    check("t3_full_ready", 32'(ready_o), 0);
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_valid", 32'(valid_o), 32'h1);
      check("t3_hold_word", 32'(word_o), 32'h10);
      tick();
    end
    base = out_cnt;
    ready_i = 4'hf;
    send(4'b0001, 8'h12);
    tick();
    check("t3_consecutive", out_cnt - base, 3);

    begin
      logic [3:0] bad[4] = '{4'b0000, 4'b0110, 4'b0011, 4'b0011};
      logic [1:0] cnts[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
      for (int i = 0; i < 4; i++) begin
        send(bad[i], 8'h30 + 8'(i));
        check("t4_drop_pulse", 32'(drop_o), 1);
        check("t4_cnt", 32'(drop_count_o), 32'(cnts[i]));
        check("t4_no_valid", 32'(valid_o), 0);
      end
    end
    tick();

    ready_i = 4'h0;
    send(4'b1000, 8'h40);
    send(4'b0100, 8'h41);
    rst_ni = 0; #1;
    check("t6_valid", 32'(valid_o), 0);
    check("t6_ready", 32'(ready_o), 0);
    check("t6_cnt", 32'(drop_count_o), 0);
    sb.delete(); exp_cnt = 0; exp_drop = 0;
    tick();
    @(negedge clk); rst_ni = 1;
    ready_i = 4'hf;
    tick();
    check("t6_ready_after", 32'(ready_o), 1);
    base = out_cnt;
    repeat (4) tick();
    check("t6_no_stale", out_cnt - base, 0);

    send(4'b0001, 8'h20);
    check("t5_valid", 32'(valid_o), 32'h1);
    send(4'b0011, 8'h21);
    check("t5_advanced", 32'(valid_o), 0);
    check("t5_cnt", 32'(drop_count_o), 1);
    check("t5_pulse", 32'(drop_o), 1);

    repeat (3) tick();
    check("drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
